// File: rtl/rca_sum_display.sv
// rca_sum_display: converts the ripple-carry adder's 5-bit sum to two BCD digits
// with a sequential double-dabble engine. It then drives a two-digit, time-multiplexed,
// active-low common-anode seven-segment display on the two rightmost board digits.
// Optional build macro: RCA_DISP_LEADING_BLANK_EN blanks the tens digit when it is zero.
module rca_sum_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [4:0] sum,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [12:0]   shreg;
    logic [12:0]   shreg_nxt;
    logic [12:0]   adj;
    logic [2:0]    iter;
    logic [2:0]    iter_nxt;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic [RW-1:0] ref_cnt;
    logic          digit_sel;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // Next-state logic: capture in IDLE, five add-3/shift steps in SHIFT, then LOAD.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        iter_nxt  = iter;
        adj       = shreg;
        if (shreg[12:9] >= 4'd5) adj[12:9] = shreg[12:9] + 4'd3;
        if (shreg[8:5]  >= 4'd5) adj[8:5]  = shreg[8:5]  + 4'd3;
        case (state)
            IDLE: begin
                if (enable) begin
                    shreg_nxt = {8'h00, sum};
                    iter_nxt  = 3'd0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nxt = adj << 1;
                iter_nxt  = iter + 3'd1;
                if (iter == 3'd4) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Conversion engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            iter  <= iter_nxt;
        end
    end

    // Display digits update only in LOAD; done pulses on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            done   <= 1'b0;
        end else begin
            done <= (state == LOAD);
            if (state == LOAD) begin
                tens_q <= shreg[12:9];
                ones_q <= shreg[8:5];
            end
        end
    end

    // Free-running refresh counter; each wrap switches to the other digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt   <= '0;
            digit_sel <= 1'b0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            digit_sel <= ~digit_sel;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Registered segment and anode drive for the currently selected digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
        end else if (!digit_sel) begin
            an  <= 4'b1110;
            seg <= decode(ones_q);
        end else begin
`ifdef RCA_DISP_LEADING_BLANK_EN
            if (tens_q == 4'd0) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
            end else begin
                an  <= 4'b1101;
                seg <= decode(tens_q);
            end
`else
            an  <= 4'b1101;
            seg <= decode(tens_q);
`endif
        end
    end

endmodule
